// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the ROM requesters, the shared rom_sync and rom_arbiter.
// slave = arbiter side; master = requesters plus ROM data source.
interface rom_arbiter_if #(
  parameter int REQS  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int RIDW  = $clog2(REQS);
  localparam int ADDRW = $clog2(DEPTH);

  logic [REQS-1:0]       req;
  logic [REQS*ADDRW-1:0] req_addr;
  logic [REQS-1:0]       ack;
  logic [ADDRW-1:0]      rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic                  rvalid;
  logic [RIDW-1:0]       rid;
  logic [WIDTH-1:0]      rdata;

  modport slave (
    input  req, req_addr, rom_data,
    output ack, rom_addr, rvalid, rid, rdata
  );

  modport master (
    output req, req_addr, rom_data,
    input  ack, rom_addr, rvalid, rid, rdata
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares one rom_sync between REQS requesters, one read per cycle, responses tagged with requester id.
// Define ROM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rom_arbiter #(
  parameter int REQS  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus
);
  localparam int RIDW  = $clog2(REQS);
  localparam int ADDRW = $clog2(DEPTH);

  logic            grant;
  logic [RIDW-1:0] win_id;
  logic            s1_valid;
  logic [RIDW-1:0] s1_id;
  logic            s2_valid;
  logic [RIDW-1:0] s2_id;
  logic [WIDTH-1:0] rdata_q;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Scanning downward leaves the lowest requesting index as the winner.
  always_comb begin
    grant  = 1'b0;
    win_id = '0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        grant  = 1'b1;
        win_id = RIDW'(i);
      end
    end
    if (rst) grant = 1'b0;
  end
`else
  logic [RIDW-1:0] rr_ptr;
  int              idx;

  // Scanning offsets downward leaves the first requester at or after rr_ptr as the winner.
  always_comb begin
    grant  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int k = REQS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQS) idx = idx - REQS;
      if (bus.req[idx]) begin
        grant  = 1'b1;
        win_id = RIDW'(idx);
      end
    end
    if (rst) grant = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (win_id == RIDW'(REQS - 1)) ? '0 : win_id + 1'b1;
    end
  end
`endif

  always_comb begin
    bus.ack = '0;
    if (grant) bus.ack[win_id] = 1'b1;
  end

  // Stage 1 follows the address into the ROM, stage 2 follows the ROM's registered data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rom_addr <= '0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      s2_valid     <= 1'b0;
      s2_id        <= '0;
      bus.rvalid   <= 1'b0;
      bus.rid      <= '0;
      rdata_q      <= '0;
    end else begin
      if (grant) begin
        bus.rom_addr <= bus.req_addr[int'(win_id)*ADDRW +: ADDRW];
        s1_valid     <= 1'b1;
        s1_id        <= win_id;
      end else begin
        s1_valid <= 1'b0;
      end
      s2_valid   <= s1_valid;
      s2_id      <= s1_id;
      bus.rvalid <= s2_valid;
      if (s2_valid) begin
        bus.rid <= s2_id;
        rdata_q <= bus.rom_data;
      end
    end
  end

  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic against a queue-based model.
// Honours ROM_ARB_FIXED_PRIO_EN in its reference model.
module tb_rom_arbiter;
  logic clk;
  logic rst;

  rom_arbiter_if #(.REQS(4), .WIDTH(8), .DEPTH(256)) bus ();

  rom_arbiter #(.REQS(4), .WIDTH(8), .DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rom_sync model: ROM[a] = a ^ 8'h5A with one cycle of read latency.
  always @(posedge clk) bus.rom_data <= bus.rom_addr ^ 8'h5A;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [7:0] data;
  } resp_t;

  resp_t      pending[$];
  int         checks   = 0;
  int         failures = 0;
  int         cycle    = 0;
  int         ptr      = 0;
  logic [7:0] expRomAddr = 8'h00;
  logic [1:0] expRid     = 2'd0;
  logic [7:0] expRdata   = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic int pickWinner(input logic [3:0] r);
    int start;
    int idx;
`ifdef ROM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (start + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkPipe();
    logic expRvalid;
    expRvalid = 1'b0;
    if (pending.size() > 0 && pending[0].due == cycle) begin
      expRvalid = 1'b1;
      expRid    = pending[0].id;
      expRdata  = pending[0].data;
      void'(pending.pop_front());
    end
    checkOutput("rom_addr", 32'(bus.rom_addr), 32'(expRomAddr));
    checkOutput("rvalid", 32'(bus.rvalid), 32'(expRvalid));
    checkOutput("rid", 32'(bus.rid), 32'(expRid));
    checkOutput("rdata", 32'(bus.rdata), 32'(expRdata));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] a);
    int         w;
    logic [3:0] expAck;
    bus.req      = r;
    bus.req_addr = a;
    #1;
    w      = pickWinner(r);
    expAck = (w >= 0) ? 4'(1 << w) : 4'b0000;
    checkOutput("ack", 32'(bus.ack), 32'(expAck));
    @(posedge clk);
    cycle++;
    if (w >= 0) begin
      pending.push_back('{due: cycle + 2, id: 2'(w), data: a[w*8 +: 8] ^ 8'h5A});
      expRomAddr = a[w*8 +: 8];
      ptr        = (w + 1) % 4;
    end
    @(negedge clk);
    checkPipe();
  endtask

  task automatic doReset();
    rst     = 1'b1;
    bus.req = 4'b1111;
    pending.delete();
    ptr        = 0;
    expRomAddr = 8'h00;
    expRid     = 2'd0;
    expRdata   = 8'h00;
    #1;
    checkOutput("ack_in_reset", 32'(bus.ack), 32'h0);
    checkOutput("rvalid_in_reset", 32'(bus.rvalid), 32'h0);
    checkOutput("rdata_in_reset", 32'(bus.rdata), 32'h0);
    checkOutput("rom_addr_in_reset", 32'(bus.rom_addr), 32'h0);
    @(posedge clk);
    cycle++;
    @(negedge clk);
    checkOutput("ack_in_reset", 32'(bus.ack), 32'h0);
    checkPipe();
    bus.req = 4'b0000;
    rst     = 1'b0;
  endtask

  initial begin
    bus.req      = 4'b0000;
    bus.req_addr = 32'h0;
    doReset();

    $display("[TB] test 1: single request from requester 0");
    applyStimulus(4'b0001, 32'h0000_0010);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 32'h0);

    $display("[TB] test 2: all four requesters held");
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, $urandom);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 32'h0);

    $display("[TB] test 3: requester 2 alone, addresses 0..4");
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 32'(i) << 16);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 32'h0);

    $display("[TB] test 4: pointer wrap then 1001");
    applyStimulus(4'b1000, 32'h3300_0000);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1001, $urandom);

    $display("[TB] test 5: reset with reads in flight");
    applyStimulus(4'b0011, 32'h0000_2211);
    applyStimulus(4'b0011, 32'h0000_4433);
    doReset();
    applyStimulus(4'b0110, 32'h0077_6600);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 32'h0);

    $display("[TB] test 6: 1010 held");
    for (int i = 0; i < 6; i++) applyStimulus(4'b1010, $urandom);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) applyStimulus(4'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 32'h0);
    checkOutput("drained", 32'(pending.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
